// File: rtl/arbiter_puf_pkg.sv
// Shared types and LFSR helpers for the arbiter PUF controller.
package arbiter_puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
  } puf_state_t;

  // Feedback taps at bits 31, 21, 1 and 0.
  localparam logic [31:0] LFSR_TAPS      = 32'h8020_0003;
  localparam logic [31:0] LFSR_SAFE_SEED = 32'h0000_0001;

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return {l[30:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/puf_resp_sync.sv
// Two-flop synchroniser bringing the raw arbiter response into the iclk domain.
module puf_resp_sync (
  input  logic iclk,
  input  logic irst_n,
  input  logic iasync,
  output logic osync
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= iasync;
      sync_q <= meta_q;
    end
  end

  assign osync = sync_q;

endmodule

// File: rtl/arbiter_puf_ctrl.sv
// Challenge generation, launch timing and response collection for an arbiter PUF.
module arbiter_puf_ctrl
  import arbiter_puf_pkg::*;
#(
  parameter int unsigned CHAL_W     = 32,
  parameter int unsigned RESP_BITS  = 32,
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned PULSE_CYC  = 4,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic                 iclk,
  input  logic                 irst_n,
  input  logic                 istart,
  input  logic [31:0]          iseed,
  output logic [CHAL_W-1:0]    ochallenge,
  output logic                 opulse,
  input  logic                 iresponse,
  output logic [RESP_BITS-1:0] oresp_word,
  output logic                 ovalid,
  output logic                 ostuck,
  output logic                 obusy
);

  localparam int unsigned MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned MAX_CYC = (MAX_SP > SETTLE_CYC) ? MAX_SP : SETTLE_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam int unsigned KW      = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

  puf_state_t           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [KW-1:0]        k_q, k_d;
  logic [31:0]          lfsr_q, lfsr_d;
  logic [CHAL_W-1:0]    chal_q, chal_d;
  logic [RESP_BITS-1:0] word_q, word_d;
  logic [RESP_BITS-1:0] resp_word_q, resp_word_d;
  logic                 stuck_q, stuck_d;
  logic                 valid_q, valid_d;
  logic                 pulse_q, pulse_d;
  logic                 resp_sync;
  logic [31:0]          seed_eff;
  logic [31:0]          lfsr_adv;

  puf_resp_sync u_sync (
    .iclk   (iclk),
    .irst_n (irst_n),
    .iasync (iresponse),
    .osync  (resp_sync)
  );

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      k_q         <= '0;
      lfsr_q      <= LFSR_SAFE_SEED;
      chal_q      <= '0;
      word_q      <= '0;
      resp_word_q <= '0;
      stuck_q     <= 1'b0;
      valid_q     <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      lfsr_q      <= lfsr_d;
      chal_q      <= chal_d;
      word_q      <= word_d;
      resp_word_q <= resp_word_d;
      stuck_q     <= stuck_d;
      valid_q     <= valid_d;
      pulse_q     <= pulse_d;
    end
  end

  // Each timed phase counts 0..N-1 and clears the counter on exit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (istart) begin
          state_d = ST_SETUP;
          cnt_d   = '0;
        end
      end
      ST_SETUP: begin
        if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
          state_d = ST_PULSE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PULSE: begin
        if (cnt_q == CNT_W'(PULSE_CYC - 1)) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          state_d = ST_CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        cnt_d   = '0;
        state_d = (k_q == KW'(RESP_BITS - 1)) ? ST_DONE : ST_SETUP;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign seed_eff = (iseed == '0) ? LFSR_SAFE_SEED : iseed;
  assign lfsr_adv = lfsr_next(lfsr_q);

  always_comb begin
    lfsr_d      = lfsr_q;
    chal_d      = chal_q;
    k_d         = k_q;
    word_d      = word_q;
    resp_word_d = resp_word_q;
    stuck_d     = stuck_q;
    valid_d     = (state_q == ST_DONE);
    // Registered from the next state so opulse is a clean flop output aligned with PULSE.
    pulse_d     = (state_d == ST_PULSE);
    unique case (state_q)
      ST_IDLE: begin
        if (istart) begin
          lfsr_d = seed_eff;
          chal_d = CHAL_W'(seed_eff);
          k_d    = '0;
          word_d = '0;
        end
      end
      ST_CAPTURE: begin
        word_d[k_q] = resp_sync;
        if (k_q != KW'(RESP_BITS - 1)) begin
          k_d    = k_q + KW'(1);
          lfsr_d = lfsr_adv;
          chal_d = CHAL_W'(lfsr_adv);
        end
      end
      ST_DONE: begin
        resp_word_d = word_q;
        stuck_d     = (&word_q) | ~(|word_q);
      end
      default: ;
    endcase
  end

  assign ochallenge = chal_q;
  assign opulse     = pulse_q;
  assign oresp_word = resp_word_q;
  assign ovalid     = valid_q;
  assign ostuck     = stuck_q;
  assign obusy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_arbiter_puf_ctrl.sv
// Directed bench for arbiter_puf_ctrl with a behavioural arbiter PUF on each instance.
module tb_arbiter_puf_ctrl;

  logic        iclk = 1'b0;
  logic        irst_n;
  logic        istart, istart4;
  logic [31:0] iseed, iseed4;
  logic [31:0] ochallenge, ochallenge4;
  logic        opulse, opulse4;
  logic        iresponse = 1'b0;
  logic        iresponse4 = 1'b0;
  logic [31:0] oresp_word;
  logic [3:0]  oresp_word4;
  logic        ovalid, ovalid4, ostuck, ostuck4, obusy, obusy4;

  int n_tests = 0;
  int n_fail  = 0;
  int model_mode = 0;

  always #5 iclk = ~iclk;

  arbiter_puf_ctrl dut (
    .iclk(iclk), .irst_n(irst_n), .istart(istart), .iseed(iseed),
    .ochallenge(ochallenge), .opulse(opulse), .iresponse(iresponse),
    .oresp_word(oresp_word), .ovalid(ovalid), .ostuck(ostuck), .obusy(obusy)
  );

  arbiter_puf_ctrl #(.RESP_BITS(4)) dut4 (
    .iclk(iclk), .irst_n(irst_n), .istart(istart4), .iseed(iseed4),
    .ochallenge(ochallenge4), .opulse(opulse4), .iresponse(iresponse4),
    .oresp_word(oresp_word4), .ovalid(ovalid4), .ostuck(ostuck4), .obusy(obusy4)
  );

  function automatic logic puf_model(input int mode, input logic [31:0] ch);
    logic [31:0] m;
    m = ch & 32'h0F0F_0F0F;
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      default: return ^m;
    endcase
  endfunction

  function automatic logic [31:0] sw_word(input logic [31:0] seed, input int mode, input int nbits);
    logic [31:0] l, w;
    l = (seed == 32'h0) ? 32'h1 : seed;
    w = 32'h0;
    for (int i = 0; i < nbits; i++) begin
      w[i] = puf_model(mode, l);
      l = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    end
    return w;
  endfunction

  // Arbiter decision is taken at the launch edge.
  always @(posedge opulse)  iresponse  <= puf_model(model_mode, ochallenge);
  always @(posedge opulse4) iresponse4 <= puf_model(model_mode, ochallenge4);

  int          rise_cnt = 0, hi_cnt = 0, chg_cnt = 0, valid_cnt = 0, valid4_cnt = 0;
  logic        prev_pulse = 1'b0;
  logic [31:0] prev_chal  = 32'h0;

  always @(negedge iclk) begin
    if (opulse) hi_cnt++;
    if (opulse && !prev_pulse) rise_cnt++;
    if (opulse && prev_pulse && ochallenge != prev_chal) chg_cnt++;
    if (ovalid) valid_cnt++;
    if (ovalid4) valid4_cnt++;
    prev_pulse = opulse;
    prev_chal  = ochallenge;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] seed;
    int          mode;
    logic [31:0] exp_word;
    logic        exp_stuck;
    logic [31:0] exp_chal;
    int          disturb;
  } vec_t;

  vec_t        vecs[5];
  logic [31:0] last_word = 32'h0;

  // Starts a run on the 32-bit instance; disturb>0 pulses istart at that cycle.
  task automatic run_main(input vec_t v);
    int r0, h0, c0, v0, cyc;
    r0 = rise_cnt; h0 = hi_cnt; c0 = chg_cnt; v0 = valid_cnt;
    model_mode = v.mode;
    iseed  = v.seed;
    istart = 1'b1;
    @(negedge iclk);
    istart = 1'b0;
    iseed  = 32'hCAFE_F00D;
    check({v.name, " first_chal"}, ochallenge, v.exp_chal);
    check({v.name, " busy"}, {31'h0, obusy}, 32'h1);
    check({v.name, " word_held"}, oresp_word, last_word);
    cyc = 0;
    while (!ovalid && cyc < 1000) begin
      @(negedge iclk);
      cyc++;
      istart = (cyc == v.disturb);
    end
    istart = 1'b0;
    check({v.name, " latency"}, cyc, 353);
    check({v.name, " word"}, oresp_word, v.exp_word);
    check({v.name, " stuck"}, {31'h0, ostuck}, {31'h0, v.exp_stuck});
    @(negedge iclk);
    check({v.name, " valid_1cyc"}, {31'h0, ovalid}, 32'h0);
    check({v.name, " idle_after"}, {31'h0, obusy}, 32'h0);
    check({v.name, " pulses"}, rise_cnt - r0, 32);
    check({v.name, " pulse_cycles"}, hi_cnt - h0, 128);
    check({v.name, " chal_stable"}, chg_cnt - c0, 0);
    check({v.name, " valid_count"}, valid_cnt - v0, 1);
    last_word = v.exp_word;
  endtask

  task automatic run_small(input string name, input logic [31:0] seed, input logic [3:0] exp);
    int cyc;
    model_mode = 2;
    iseed4  = seed;
    istart4 = 1'b1;
    @(negedge iclk);
    istart4 = 1'b0;
    cyc = 0;
    while (!ovalid4 && cyc < 200) begin
      @(negedge iclk);
      cyc++;
    end
    check({name, " latency"}, cyc, 45);
    check({name, " word"}, {28'h0, oresp_word4}, {28'h0, exp});
    @(negedge iclk);
  endtask

  initial begin
    logic [31:0] w_dead, w_1234, w4;
    int v0, cyc;
    w_dead = sw_word(32'hDEAD_BEEF, 2, 32);
    w_1234 = sw_word(32'h1234_5678, 2, 32);
    w4     = sw_word(32'h1, 2, 4);
    vecs[0] = '{"seed0_const1", 32'h0, 1, 32'hFFFF_FFFF, 1'b1, 32'h1, -1};
    vecs[1] = '{"seed0_const0", 32'h0, 0, 32'h0, 1'b1, 32'h1, -1};
    vecs[2] = '{"deadbeef_parity", 32'hDEAD_BEEF, 2, w_dead, 1'b0, 32'hDEAD_BEEF, -1};
    vecs[3] = '{"restart_ignored", 32'hDEAD_BEEF, 2, w_dead, 1'b0, 32'hDEAD_BEEF, 100};
    vecs[4] = '{"start_in_done", 32'h1234_5678, 2, w_1234,
                (w_1234 == 32'h0) || (w_1234 == 32'hFFFF_FFFF), 32'h1234_5678, 352};

    irst_n = 1'b0; istart = 1'b0; istart4 = 1'b0; iseed = 32'h0; iseed4 = 32'h0;
    repeat (3) @(negedge iclk);
    check("rst ochallenge", ochallenge, 32'h0);
    check("rst outs", {26'h0, opulse, ovalid, ostuck, obusy, opulse4, obusy4}, 32'h0);
    check("rst oresp_word", oresp_word, 32'h0);
    check("rst dut4 chal", ochallenge4, 32'h0);
    irst_n = 1'b1;
    @(negedge iclk);

    // Reset asserted during the first SETTLE phase.
    model_mode = 1;
    iseed  = 32'h5555_AAAA;
    istart = 1'b1;
    @(negedge iclk);
    istart = 1'b0;
    for (cyc = 0; cyc < 7; cyc++) @(negedge iclk);
    check("pre_abort busy", {31'h0, obusy}, 32'h1);
    irst_n = 1'b0;
    #1;
    check("abort chal", ochallenge, 32'h0);
    check("abort outs", {28'h0, opulse, ovalid, ostuck, obusy}, 32'h0);
    @(negedge iclk);
    irst_n = 1'b1;
    v0 = valid_cnt;
    repeat (400) @(negedge iclk);
    check("abort no_valid", valid_cnt - v0, 0);
    check("abort idle", {31'h0, obusy}, 32'h0);

    for (int i = 0; i < 5; i++) run_main(vecs[i]);
    check("done_start busy", {31'h0, obusy}, 32'h0);

    run_small("rb4_run1", 32'h1, w4[3:0]);
    run_small("rb4_run2", 32'h1, w4[3:0]);
    check("rb4 valid_count", valid4_cnt, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
